// File: rtl/uart_rx_serial.sv
// 8N1 UART receiver: two-flop rx synchroniser, start-edge-timed mid-bit sampling,
// LSB-first deserialiser with stop-bit check, single-cycle rcv / frame_err strobes.
module uart_rx_serial #(
    parameter int unsigned BAUD_DIV = 1250
) (
    input  logic       clk,
    input  logic       rstn,
    input  logic       rx,
    output logic [7:0] data,
    output logic       rcv,
    output logic       busy,
    output logic       frame_err
);

    localparam int unsigned HALF = BAUD_DIV >> 1;
    localparam int unsigned CW   = $clog2(BAUD_DIV);

    localparam logic [CW-1:0] HALF_LAST = CW'(HALF - 1);
    localparam logic [CW-1:0] BIT_LAST  = CW'(BAUD_DIV - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_START,
        S_DATA,
        S_STOP,
        S_WAIT_HIGH
    } state_t;

    state_t        state;
    logic          rx_m;
    logic          rx_s;
    logic [CW-1:0] cnt;
    logic [2:0]    bitcnt;
    logic [7:0]    shift;

    always_ff @(posedge clk) begin
        if (!rstn) begin
            rx_m      <= 1'b1;
            rx_s      <= 1'b1;
            state     <= S_IDLE;
            cnt       <= '0;
            bitcnt    <= '0;
            shift     <= '0;
            data      <= '0;
            rcv       <= 1'b0;
            frame_err <= 1'b0;
            busy      <= 1'b0;
        end else begin
            rx_m      <= rx;
            rx_s      <= rx_m;
            rcv       <= 1'b0;
            frame_err <= 1'b0;
            cnt       <= cnt + CW'(1);

            case (state)
                S_IDLE: begin
                    if (!rx_s) begin
                        state <= S_START;
                        cnt   <= '0;
                        busy  <= 1'b1;
                    end
                end

                // A start bit that is high again at its mid-point is a glitch.
                S_START: begin
                    if (cnt == HALF_LAST) begin
                        cnt <= '0;
                        if (!rx_s) begin
                            state  <= S_DATA;
                            bitcnt <= '0;
                        end else begin
                            state <= S_IDLE;
                            busy  <= 1'b0;
                        end
                    end
                end

                S_DATA: begin
                    if (cnt == BIT_LAST) begin
                        cnt    <= '0;
                        shift  <= {rx_s, shift[7:1]};
                        bitcnt <= bitcnt + 3'd1;
                        if (bitcnt == 3'd7) begin
                            state <= S_STOP;
                        end
                    end
                end

                S_STOP: begin
                    if (cnt == BIT_LAST) begin
                        cnt <= '0;
                        if (rx_s) begin
                            data  <= shift;
                            rcv   <= 1'b1;
                            state <= S_IDLE;
                            busy  <= 1'b0;
                        end else begin
                            frame_err <= 1'b1;
                            state     <= S_WAIT_HIGH;
                        end
                    end
                end

                // Hold off through a break so a low line is not taken as a new start.
                S_WAIT_HIGH: begin
                    if (rx_s) begin
                        state <= S_IDLE;
                        cnt   <= '0;
                        busy  <= 1'b0;
                    end
                end

                default: begin
                    state <= S_IDLE;
                    cnt   <= '0;
                    busy  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_uart_rx_serial.sv
// Directed bench for uart_rx_serial at BAUD_DIV=16: framing, timing, glitch,
// stop-bit error, back-to-back frames and mid-frame reset.
module tb_uart_rx_serial;

    localparam int unsigned BD = 16;

    logic       clk;
    logic       rstn;
    logic       rx;
    logic [7:0] data;
    logic       rcv;
    logic       busy;
    logic       frame_err;

    uart_rx_serial #(.BAUD_DIV(BD)) dut (
        .clk       (clk),
        .rstn      (rstn),
        .rx        (rx),
        .data      (data),
        .rcv       (rcv),
        .busy      (busy),
        .frame_err (frame_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int         tot_rcv = 0;
    int         tot_ferr = 0;
    int         tot_busy = 0;
    int         viol = 0;
    int         last_rcv_cyc = 0;
    int         prev_rcv_cyc = 0;
    logic [7:0] last_rcv_dat = '0;
    logic [7:0] prev_rcv_dat = '0;
    logic       prev_pulse = 1'b0;

    always @(negedge clk) begin
        if (rcv === 1'b1) begin
            tot_rcv      <= tot_rcv + 1;
            prev_rcv_cyc <= last_rcv_cyc;
            prev_rcv_dat <= last_rcv_dat;
            last_rcv_cyc <= cyc;
            last_rcv_dat <= data;
        end
        if (frame_err === 1'b1) tot_ferr <= tot_ferr + 1;
        if (busy === 1'b1) tot_busy <= tot_busy + 1;
        if ((rcv === 1'b1 && frame_err === 1'b1) ||
            ((rcv === 1'b1 || frame_err === 1'b1) && prev_pulse))
            viol <= viol + 1;
        prev_pulse <= (rcv === 1'b1) || (frame_err === 1'b1);
    end

    int vectors = 0;
    int miscompares = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        vectors++;
        if (got !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic drive(input logic v, input int n);
        rx = v;
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic send_frame(input logic [7:0] b, input logic stop_v,
                              input int stop_len, output int fall_cyc);
        fall_cyc = cyc;
        drive(1'b0, BD);
        for (int i = 0; i < 8; i++) drive(b[i], BD);
        drive(stop_v, stop_len);
    endtask

    int f0, f1, r0, e0, b0;

    initial begin
        rstn = 1'b0;
        rx   = 1'b1;
        @(posedge clk);
        #1;
        drive(1'b1, 3);
        chk("rst_data", 32'(data), 32'h00);
        chk("rst_rcv", 32'(rcv), 0);
        chk("rst_busy", 32'(busy), 0);
        chk("rst_ferr", 32'(frame_err), 0);
        rstn = 1'b1;
        drive(1'b1, 10);

        // Single frame: rcv lands 2 sync + 8 half + 9*16 bits + 1 after the pin edge.
        r0 = tot_rcv;
        send_frame(8'h55, 1'b1, BD, f0);
        drive(1'b1, 20);
        chk("x55_count", 32'(tot_rcv - r0), 1);
        chk("x55_data", 32'(data), 32'h55);
        chk("x55_latency", 32'(last_rcv_cyc - f0), 155);
        chk("x55_busy_after", 32'(busy), 0);

        // Back-to-back frames with no idle gap.
        r0 = tot_rcv;
        send_frame(8'hA3, 1'b1, BD, f0);
        send_frame(8'h0F, 1'b1, BD, f1);
        drive(1'b1, 20);
        chk("b2b_count", 32'(tot_rcv - r0), 2);
        chk("b2b_spacing", 32'(last_rcv_cyc - prev_rcv_cyc), 160);
        chk("b2b_first", 32'(prev_rcv_dat), 32'hA3);
        chk("b2b_second", 32'(last_rcv_dat), 32'h0F);
        chk("b2b_first_lat", 32'(prev_rcv_cyc - f0), 155);

        // Short glitch is rejected at the start-bit mid-point.
        r0 = tot_rcv;
        e0 = tot_ferr;
        b0 = tot_busy;
        drive(1'b0, 5);
        drive(1'b1, 30);
        chk("glitch_rcv", 32'(tot_rcv - r0), 0);
        chk("glitch_ferr", 32'(tot_ferr - e0), 0);
        chk("glitch_busy_len_ok", 32'((tot_busy - b0) <= 8 && (tot_busy - b0) >= 1), 1);
        chk("glitch_idle", 32'(busy), 0);
        chk("glitch_data_kept", 32'(data), 32'h0F);

        // Low stop bit held for 40 cycles.
        r0 = tot_rcv;
        e0 = tot_ferr;
        send_frame(8'hC6, 1'b0, 40, f0);
        chk("ferr_busy_held", 32'(busy), 1);
        chk("ferr_pulse", 32'(tot_ferr - e0), 1);
        drive(1'b1, 20);
        chk("ferr_busy_clear", 32'(busy), 0);
        chk("ferr_no_rcv", 32'(tot_rcv - r0), 0);
        chk("ferr_data_kept", 32'(data), 32'h0F);
        chk("ferr_single", 32'(tot_ferr - e0), 1);

        r0 = tot_rcv;
        send_frame(8'h7E, 1'b1, BD, f0);
        drive(1'b1, 20);
        chk("after_ferr_count", 32'(tot_rcv - r0), 1);
        chk("after_ferr_data", 32'(data), 32'h7E);

        // Reset during data bit 4 of 0xFF aborts the frame silently.
        r0 = tot_rcv;
        e0 = tot_ferr;
        drive(1'b0, BD);
        for (int i = 0; i < 4; i++) drive(1'b1, BD);
        drive(1'b1, 8);
        rstn = 1'b0;
        drive(1'b1, 3);
        rstn = 1'b1;
        chk("abort_data", 32'(data), 32'h00);
        chk("abort_busy", 32'(busy), 0);
        drive(1'b1, 200);
        chk("abort_no_rcv", 32'(tot_rcv - r0), 0);
        chk("abort_no_ferr", 32'(tot_ferr - e0), 0);
        chk("abort_data_hold", 32'(data), 32'h00);
        send_frame(8'h12, 1'b1, BD, f0);
        drive(1'b1, 20);
        chk("post_abort_count", 32'(tot_rcv - r0), 1);
        chk("post_abort_data", 32'(data), 32'h12);

        chk("strobe_exclusive", 32'(viol), 0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/uart_rx_serial.md
Name: uart_rx_serial

Overview:
8N1 UART receiver, the receive-side counterpart of the team's baud tick generator and serial transmitter. It contains its own baud divider and samples mid-bit, timed from the detected start edge. It synchronises the asynchronous rx line, deserialises LSB-first, checks the stop bit, and presents a byte with a one-cycle valid strobe to the consumer logic on the 12 MHz system clock.

Parameters:
BAUD_DIV, 1250, clk cycles per bit (12000000/baud; 1250 = 9600 baud); must be >= 8
HALF, BAUD_DIV>>1, localparam: cycles from start edge to start-bit mid-point

Ports:
clk  input  1  system clock (12 MHz)
rstn  input  1  synchronous reset, active-low, sampled on posedge clk
rx  input  1  asynchronous serial line, idle high
data  output  8  last correctly framed byte; holds until next good frame
rcv  output  1  one-cycle pulse: data updated
busy  output  1  high while a frame is in progress (any state except IDLE)
frame_err  output  1  one-cycle pulse: stop bit sampled low

Behaviour:
- Reset (rstn=0 at posedge): state=IDLE, data=8'h00, rcv=0, frame_err=0, busy=0, bit counter=0, divider=0, both synchroniser flops=1. Reset mid-frame aborts the frame silently; no rcv and no frame_err.
- Synchroniser: two flops, rx -> rx_s. All logic uses rx_s only. Pin-to-rx_s latency is 2 cycles.
- Divider cnt, width $clog2(BAUD_DIV). Cleared to 0 on every state entry except DATA->DATA; otherwise increments by 1 each cycle.
- FSM states: IDLE, START, DATA, STOP, WAIT_HIGH.
  - IDLE: when rx_s==0 (level, line idle high) -> START, cnt=0.
  - START: sample when cnt==HALF-1. If rx_s==0 -> DATA, cnt=0, bitcnt=0. If rx_s==1 (glitch/false start) -> IDLE, no outputs.
  - DATA: sample when cnt==BAUD_DIV-1. Shift rx_s into shift[7] (right shift, LSB first), cnt=0, bitcnt+1. After the 8th sample -> STOP.
  - STOP: sample when cnt==BAUD_DIV-1.
    - If rx_s==1: data<=shift, rcv=1 for the next cycle, -> IDLE.
    - If rx_s==0: frame_err=1 for the next cycle, data unchanged, -> WAIT_HIGH.
  - WAIT_HIGH: stay until rx_s==1, then -> IDLE. This covers a break condition with no spurious start.
- Sample instants relative to the cycle rx_s first reads 0 (call it T0, the entry to START at T0+1):
  - start-bit check at T0+HALF
  - data bit k at T0+HALF+(k+1)*BAUD_DIV
  - stop bit at T0+HALF+9*BAUD_DIV
  - rcv/frame_err high in the following cycle
- Back-to-back frames: IDLE is re-entered immediately after the stop sample. A start edge arriving in the second half of the stop bit is accepted on the next cycle. No dead time beyond one cycle.
- rcv and frame_err are mutually exclusive and never high two consecutive cycles.
- Consumer has no backpressure. A new byte overwrites data. The consumer must capture data on rcv.

Test Plan:
- BAUD_DIV=16, rstn=0 for 3 cycles, rx=1 -> data=0x00, rcv=0, busy=0, frame_err=0 throughout.
- Send 0x55 with a valid stop (bit period 16 clk) -> exactly one rcv pulse, data=0x55, pulse occurs 2+8+9*16+1 cycles after the rx falling edge (±1), busy low afterwards.
- Send 0xA3 then 0x0F back-to-back with no idle gap -> two rcv pulses exactly 160 cycles apart, data=0xA3 then 0x0F.
- rx low for 5 cycles then high (glitch < HALF) -> no rcv, no frame_err, FSM returns to IDLE, busy high for ≤ 8 cycles.
- Send 0xC6 with the stop bit held low for 40 cycles -> frame_err single pulse, data keeps previous value, no rcv, busy stays high until rx returns high. A subsequent 0x7E is received correctly.
- Assert rstn=0 during data bit 4 of 0xFF, release, then send 0x12 -> no output from the aborted frame, data=0x00 after reset, then data=0x12 with one rcv.
